bin_bcd_encoder: RTL and testbench

BIN_BCD_ENCODER -- requirements
Module: bin_bcd_encoder

---
 rtl/bin_bcd_encoder_pkg.sv | 12 +
 rtl/bcd_add3.sv | 17 +
 rtl/bin_bcd_encoder.sv | 114 +++++++++++
 tb/tb_bin_bcd_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bin_bcd_encoder_pkg.sv
// Shared types and constants for the binary-to-BCD encoder.
package bin_bcd_encoder_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage : bin_bcd_encoder_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin_bcd_encoder_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout_c
);

  // Pre-shift correction so the following left shift carries into the next digit
  always_comb begin
    dout_c = din;
    if (din >= DIGIT_W'(5)) begin
      dout_c = din + DIGIT_W'(3);
    end
  end

endmodule : bcd_add3

// File: rtl/bin_bcd_encoder.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
module bin_bcd_encoder
  import bin_bcd_encoder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       START,
  input  logic [WIDTH-1:0]           BIN,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [DIGIT_W*DIGITS-1:0]  BCD
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned CAT_W = BCD_W + WIDTH;

  // Refuse to build a configuration whose largest input does not fit the digits
  if ((64'(10) ** DIGITS) <= ((64'(1) << WIDTH) - 64'(1))) begin : g_overflow_check
    $error("bin_bcd_encoder: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   shreg_q,   shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [BCD_W-1:0]   bcd_q,     bcd_d;

  logic [BCD_W-1:0]   corr_c;
  logic [CAT_W-1:0]   shifted_c;

  // One correction cell per scratch digit
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din    (scratch_q[DIGIT_W*i +: DIGIT_W]),
      .dout_c (corr_c[DIGIT_W*i +: DIGIT_W])
    );
  end

  // Corrected scratch concatenated with the remaining input bits, shifted left one
  always_comb begin
    shifted_c = {corr_c, shreg_q} << 1;
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          shreg_d   = BIN;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted_c[CAT_W-1:WIDTH];
        shreg_d   = shifted_c[WIDTH-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign BCD  = bcd_q;

endmodule : bin_bcd_encoder

// File: tb/tb_bin_bcd_encoder.sv
// Self-checking bench for bin_bcd_encoder against a decimal-arithmetic reference.
module tb_bin_bcd_encoder;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic              CLK;
  logic              RST_N;
  logic              START;
  logic [WIDTH-1:0]  BIN;
  logic              BUSY;
  logic              DONE;
  logic [BW-1:0]     BCD;

  int total = 0;
  int bad   = 0;

  bin_bcd_encoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .BCD   (BCD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Decimal digits of v, units digit in the low nibble
  function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion from an idle block; optional extra START at edge restart_edge,
  // optional BIN cleared right after the accepting edge
  task automatic do_conv(input logic [WIDTH-1:0] v, input int restart_edge,
                         input bit drop_bin, input string tag);
    logic [BW-1:0] exp_bcd;
    logic [BW-1:0] prev_bcd;
    int n;
    int busy_cnt;
    bit seen;
    bit stable;
    exp_bcd  = ref_bcd(32'(v));
    prev_bcd = BCD;
    START = 1'b1;
    BIN   = v;
    @(negedge CLK);
    START = 1'b0;
    if (drop_bin) BIN = '0;
    busy_cnt = BUSY ? 1 : 0;
    stable   = (BCD === prev_bcd);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3 * WIDTH) begin
      START = (n + 1 == restart_edge);
      @(negedge CLK);
      n++;
      if (DONE) seen = 1'b1;
      else begin
        if (BUSY) busy_cnt++;
        if (BCD !== prev_bcd) stable = 1'b0;
      end
    end
    START = 1'b0;
    chk({tag, ":latency"},      32'(n),        32'(WIDTH + 1));
    chk({tag, ":bcd"},          32'(BCD),      32'(exp_bcd));
    chk({tag, ":busy_cycles"},  32'(busy_cnt), 32'(WIDTH + 1));
    chk({tag, ":busy_at_done"}, 32'(BUSY),     32'(0));
    chk({tag, ":bcd_stable"},   32'(stable),   32'(1));
    @(negedge CLK);
    chk({tag, ":done_one_cycle"}, 32'(DONE), 32'(0));
  endtask

  // Count DONE pulses over a window with START held low
  task automatic count_idle_done(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (DONE) pulses++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic [WIDTH-1:0] v;

    RST_N = 1'b0;
    START = 1'b0;
    BIN   = '0;
    #3;
    chk("reset:busy", 32'(BUSY), 32'(0));
    chk("reset:done", 32'(DONE), 32'(0));
    chk("reset:bcd",  32'(BCD),  32'(0));
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    count_idle_done(4, pulses);
    chk("idle:no_done", 32'(pulses), 32'(0));

    // Directed corner values
    do_conv(8'd255, 0, 1'b0, "v255");
    chk("v255:const", 32'(BCD), 32'h255);
    do_conv(8'd0, 0, 1'b0, "v0");
    chk("v0:const", 32'(BCD), 32'h000);
    do_conv(8'd99, 0, 1'b0, "v99");
    chk("v99:const", 32'(BCD), 32'h099);
    do_conv(8'd100, 0, 1'b0, "v100");
    chk("v100:const", 32'(BCD), 32'h100);

    // START again at edge 4 of a running conversion is ignored
    do_conv(8'd200, 4, 1'b0, "restart");
    chk("restart:const", 32'(BCD), 32'h200);
    count_idle_done(2 * WIDTH, pulses);
    chk("restart:no_extra_done", 32'(pulses), 32'(0));

    // BIN cleared after the accepting edge has no effect
    do_conv(8'd150, 0, 1'b1, "binchg");
    chk("binchg:const", 32'(BCD), 32'h150);

    // Held START gives back-to-back conversions
    START = 1'b1;
    BIN   = 8'd42;
    @(negedge CLK);
    BIN = 8'd7;
    n = 0;
    while (!DONE && n < 4 * WIDTH) begin
      @(negedge CLK);
      n++;
    end
    chk("b2b:first_latency", 32'(n), 32'(WIDTH + 1));
    chk("b2b:first_bcd", 32'(BCD), 32'h042);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!DONE && n < 4 * WIDTH);
    START = 1'b0;
    chk("b2b:period", 32'(n), 32'(WIDTH + 2));
    chk("b2b:second_bcd", 32'(BCD), 32'h007);
    count_idle_done(2 * WIDTH, pulses);
    chk("b2b:no_third_done", 32'(pulses), 32'(0));
    chk("b2b:idle_busy", 32'(BUSY), 32'(0));

    // Reset in the middle of a conversion aborts it
    START = 1'b1;
    BIN   = 8'd123;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("midrst:busy", 32'(BUSY), 32'(0));
    chk("midrst:done", 32'(DONE), 32'(0));
    chk("midrst:bcd",  32'(BCD),  32'(0));
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    do_conv(8'd77, 0, 1'b0, "after_rst");
    chk("after_rst:const", 32'(BCD), 32'h077);
    count_idle_done(2 * WIDTH, pulses);
    chk("after_rst:no_done", 32'(pulses), 32'(0));

    // Randomized conversions with random stray START and BIN changes
    for (int k = 0; k < 24; k++) begin
      v = WIDTH'($urandom_range(0, 255));
      do_conv(v, int'($urandom_range(0, WIDTH + 1)), bit'($urandom_range(0, 1)), "rand");
    end

    // Exhaustive sweep over all input values
    for (int k = 0; k < (1 << WIDTH); k++) begin
      do_conv(WIDTH'(k), 0, 1'b0, "sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bin_bcd_encoder
